// File: rtl/multi_digit_display.sv
// Multiplexed seven-segment display driver: captures a binary value on Load,
// converts it to BCD by shift-and-add-3, and scans the digits with optional
// leading-zero blanking, overflow dashes and blinking.
module multi_digit_display #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned IN_WIDTH   = 16,
    parameter int unsigned DIV_BITS   = 17,
    parameter int unsigned BLINK_BITS = 25
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic [IN_WIDTH-1:0]   Number,
    input  logic                  Load,
    input  logic                  Blank_lz,
    input  logic                  Blink_en,
    output logic                  Busy,
    output logic                  Valid,
    output logic                  Overflow,
    output logic [6:0]            out7,
    output logic [NUM_DIGITS-1:0] en_out
);

    localparam int unsigned BCD_W = 4 * NUM_DIGITS;
    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned CNT_W = $clog2(IN_WIDTH);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b1111110;
    localparam logic [NUM_DIGITS-1:0] EN_RST = ~NUM_DIGITS'(1);

    function automatic longint unsigned pow10(input int unsigned n);
        longint unsigned p;
        p = 64'd1;
        for (int unsigned i = 0; i < n; i++) p = p * 64'd10;
        return p;
    endfunction

    localparam longint unsigned LIMIT = pow10(NUM_DIGITS);

    // One double-dabble step: correct every digit >= 5, then shift in the next bit.
    // Digits above NUM_DIGITS are dropped; they never feed lower digits.
    function automatic logic [BCD_W-1:0] dd_step(input logic [BCD_W-1:0] b, input logic bit_in);
        logic [BCD_W-1:0] a;
        a = b;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (a[i*4 +: 4] >= 4'd5) a[i*4 +: 4] = a[i*4 +: 4] + 4'd3;
        end
        return {a[BCD_W-2:0], bit_in};
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b0000001;
            4'd1:    return 7'b1001111;
            4'd2:    return 7'b0010010;
            4'd3:    return 7'b0000110;
            4'd4:    return 7'b1001100;
            4'd5:    return 7'b0100100;
            4'd6:    return 7'b0100000;
            4'd7:    return 7'b0001111;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0000100;
            default: return SEG_BLANK;
        endcase
    endfunction

    typedef enum logic {IDLE, CONVERT} state_t;

    state_t                  state;
    logic [IN_WIDTH-1:0]     value;
    logic [IN_WIDTH-1:0]     shreg;
    logic [BCD_W-1:0]        bcd;
    logic [BCD_W-1:0]        bcd_step;
    logic [CNT_W-1:0]        cnt;
    logic [BCD_W-1:0]        digits;

    logic [DIV_BITS-1:0]     refresh_cnt;
    logic [DIV_BITS-1:0]     refresh_n;
    logic [BLINK_BITS-1:0]   blink_cnt;
    logic [BLINK_BITS-1:0]   blink_n;
    logic [IDX_W-1:0]        idx;
    logic [IDX_W-1:0]        idx_n;
    logic [NUM_DIGITS-1:0]   zero_above;
    logic                    zero_run;
    logic [3:0]              sel_digit;
    logic [6:0]              glyph;
    logic [NUM_DIGITS-1:0]   en_n;

    // Next BCD accumulator value, consuming the current MSB of the shift register.
    always_comb begin
        bcd_step = dd_step(bcd, shreg[IN_WIDTH-1]);
    end

    // Capture/convert FSM; display registers commit on the last shift.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state    <= IDLE;
            Busy     <= 1'b0;
            Valid    <= 1'b0;
            Overflow <= 1'b0;
            value    <= '0;
            shreg    <= '0;
            bcd      <= '0;
            cnt      <= '0;
            digits   <= '1;
        end else begin
            case (state)
                IDLE: begin
                    if (Load) begin
                        value <= Number;
                        shreg <= Number;
                        bcd   <= '0;
                        cnt   <= '0;
                        Busy  <= 1'b1;
                        state <= CONVERT;
                    end
                end
                CONVERT: begin
                    bcd   <= bcd_step;
                    shreg <= {shreg[IN_WIDTH-2:0], 1'b0};
                    cnt   <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(IN_WIDTH - 1)) begin
                        state    <= IDLE;
                        Busy     <= 1'b0;
                        Valid    <= 1'b1;
                        Overflow <= (64'(value) >= LIMIT);
                        digits   <= bcd_step;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Next scan position, blink phase and glyph for the digit about to be driven.
    always_comb begin
        refresh_n = refresh_cnt + DIV_BITS'(1);
        blink_n   = blink_cnt + BLINK_BITS'(1);
        idx_n     = idx;
        if (&refresh_cnt) begin
            idx_n = (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
        end

        zero_above = '0;
        zero_run   = 1'b1;
        for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
            zero_run      = zero_run & (digits[i*4 +: 4] == 4'd0);
            zero_above[i] = zero_run;
        end

        sel_digit = digits[int'(idx_n)*4 +: 4];
        if (!Valid) begin
            glyph = SEG_BLANK;
        end else if (Overflow) begin
            glyph = SEG_DASH;
        end else if (Blank_lz && (idx_n != '0) && zero_above[idx_n]) begin
            glyph = SEG_BLANK;
        end else begin
            glyph = seg7(sel_digit);
        end

        en_n = '1;
        if (!(Blink_en && blink_n[BLINK_BITS-1])) en_n[idx_n] = 1'b0;
    end

    // Free-running scan and blink counters with registered enable/segment outputs.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            refresh_cnt <= '0;
            blink_cnt   <= '0;
            idx         <= '0;
            en_out      <= EN_RST;
            out7        <= SEG_BLANK;
        end else begin
            refresh_cnt <= refresh_n;
            blink_cnt   <= blink_n;
            idx         <= idx_n;
            en_out      <= en_n;
            out7        <= glyph;
        end
    end

endmodule

// File: tb/tb_multi_digit_display.sv
// Self-checking bench for multi_digit_display (4 digits, 16-bit input, fast scan).
module tb_multi_digit_display;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b1;
    logic [15:0] Number = '0;
    logic        Load = 1'b0;
    logic        Blank_lz = 1'b0;
    logic        Blink_en = 1'b0;
    logic        Busy;
    logic        Valid;
    logic        Overflow;
    logic [6:0]  out7;
    logic [3:0]  en_out;

    multi_digit_display #(
        .NUM_DIGITS(4),
        .IN_WIDTH  (16),
        .DIV_BITS  (2),
        .BLINK_BITS(6)
    ) dut (
        .Clk     (Clk),
        .Rst_n   (Rst_n),
        .Number  (Number),
        .Load    (Load),
        .Blank_lz(Blank_lz),
        .Blink_en(Blink_en),
        .Busy    (Busy),
        .Valid   (Valid),
        .Overflow(Overflow),
        .out7    (out7),
        .en_out  (en_out)
    );

    always #5 Clk = ~Clk;

    // Clock edges since reset release: slot = (k/4)%4, blink dark when k%64 >= 32.
    int k = 0;
    always @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) k <= 0;
        else        k <= k + 1;
    end

    int errors = 0;
    int checks = 0;
    int prev_val = 0;
    logic prev_valid = 1'b0;
    logic [6:0] seg_tab [10];

    typedef struct {
        int          num;
        logic        blz;
        logic        ovf;
        logic [27:0] glyphs;   // digit 3 .. digit 0
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic logic [6:0] exp_glyph(input int val, input int pos, input logic blz, input logic vld);
        int p;
        p = 1;
        for (int i = 0; i < pos; i++) p = p * 10;
        if (!vld) return 7'b1111111;
        if (val >= 10000) return 7'b1111110;
        if (blz && pos > 0 && val < p) return 7'b1111111;
        return seg_tab[(val / p) % 10];
    endfunction

    function automatic logic [3:0] exp_en();
        int idx;
        idx = (k / 4) % 4;
        if (Blink_en && (k % 64) >= 32) return 4'hF;
        return 4'hF ^ (4'b0001 << idx);
    endfunction

    task automatic start_load(input int num);
        Number = 16'(num);
        Load = 1'b1;
        @(negedge Clk);
        Load = 1'b0;
    endtask

    // Count busy cycles while the previous display must stay untouched.
    task automatic run_convert(input int inject_at, input int inj_num, output int n, output int bad);
        n = 0;
        bad = 0;
        while (Busy && n < 40) begin
            if (out7 !== exp_glyph(prev_val, (k / 4) % 4, Blank_lz, prev_valid)) bad++;
            if (en_out !== exp_en()) bad++;
            n++;
            if (n == inject_at) begin
                Number = 16'(inj_num);
                Load = 1'b1;
            end else begin
                Load = 1'b0;
            end
            @(negedge Clk);
        end
        Load = 1'b0;
    endtask

    task automatic check_disp(input string name, input int val, input logic vld);
        int bad;
        bad = 0;
        @(negedge Clk);
        for (int c = 0; c < 16; c++) begin
            if (out7 !== exp_glyph(val, (k / 4) % 4, Blank_lz, vld)) bad++;
            if (en_out !== exp_en()) bad++;
            @(negedge Clk);
        end
        check(name, bad, 0);
    endtask

    initial begin
        int n;
        int bad;
        int ones;
        int num;
        logic [27:0] g;
        logic [6:0] eg;

        seg_tab[0] = 7'b0000001; seg_tab[1] = 7'b1001111; seg_tab[2] = 7'b0010010;
        seg_tab[3] = 7'b0000110; seg_tab[4] = 7'b1001100; seg_tab[5] = 7'b0100100;
        seg_tab[6] = 7'b0100000; seg_tab[7] = 7'b0001111; seg_tab[8] = 7'b0000000;
        seg_tab[9] = 7'b0000100;

        vecs[0] = '{4029,  1'b0, 1'b0, {7'b1001100, 7'b0000001, 7'b0010010, 7'b0000100}};
        vecs[1] = '{10000, 1'b0, 1'b1, {4{7'b1111110}}};
        vecs[2] = '{9999,  1'b0, 1'b0, {4{7'b0000100}}};
        vecs[3] = '{7,     1'b1, 1'b0, {7'b1111111, 7'b1111111, 7'b1111111, 7'b0001111}};
        vecs[4] = '{7,     1'b0, 1'b0, {7'b0000001, 7'b0000001, 7'b0000001, 7'b0001111}};
        vecs[5] = '{0,     1'b1, 1'b0, {7'b1111111, 7'b1111111, 7'b1111111, 7'b0000001}};

        // Reset values.
        #1 Rst_n = 1'b0;
        @(negedge Clk);
        check("rst_busy", int'(Busy), 0);
        check("rst_valid", int'(Valid), 0);
        check("rst_overflow", int'(Overflow), 0);
        check("rst_en_out", int'(en_out), 4'b1110);
        check("rst_out7", int'(out7), 7'b1111111);
        @(negedge Clk);
        Rst_n = 1'b1;

        // Directed vectors; the first load lands on the first edge after reset.
        foreach (vecs[v]) begin
            Blank_lz = vecs[v].blz;
            start_load(vecs[v].num);
            run_convert(-1, 0, n, bad);
            check($sformatf("vec%0d_busy_cycles", v), n, 16);
            check($sformatf("vec%0d_hold_during_convert", v), bad, 0);
            check($sformatf("vec%0d_valid", v), int'(Valid), 1);
            check($sformatf("vec%0d_overflow", v), int'(Overflow), int'(vecs[v].ovf));
            @(negedge Clk);
            bad = 0;
            g = vecs[v].glyphs;
            for (int c = 0; c < 16; c++) begin
                eg = g[((k / 4) % 4) * 7 +: 7];
                if (out7 !== eg) bad++;
                if (en_out !== exp_en()) bad++;
                @(negedge Clk);
            end
            check($sformatf("vec%0d_display", v), bad, 0);
            prev_val = vecs[v].num;
            prev_valid = 1'b1;
        end

        // Second Load during conversion is ignored.
        Blank_lz = 1'b0;
        start_load(1234);
        run_convert(5, 5678, n, bad);
        check("ignored_load_busy_cycles", n, 16);
        check("ignored_load_hold", bad, 0);
        prev_val = 1234;
        check_disp("ignored_load_display", 1234, 1'b1);
        check("ignored_load_no_restart", int'(Busy), 0);

        // Reset in the middle of a conversion.
        start_load(4321);
        for (int c = 1; c < 8; c++) @(negedge Clk);
        #2 Rst_n = 1'b0;
        #1;
        check("midrst_busy", int'(Busy), 0);
        check("midrst_valid", int'(Valid), 0);
        check("midrst_overflow", int'(Overflow), 0);
        check("midrst_en_out", int'(en_out), 4'b1110);
        check("midrst_out7", int'(out7), 7'b1111111);
        @(negedge Clk);
        Rst_n = 1'b1;
        prev_valid = 1'b0;
        check_disp("midrst_blank", 0, 1'b0);
        check("midrst_idle", int'(Busy), 0);
        start_load(56);
        run_convert(-1, 0, n, bad);
        check("midrst_reload_busy", n, 16);
        check("midrst_blank_during_convert", bad, 0);
        prev_val = 56;
        prev_valid = 1'b1;
        check_disp("midrst_reload_display", 56, 1'b1);

        // Blink: dark for half of every 64-cycle period, scan continues.
        Blink_en = 1'b1;
        @(negedge Clk);
        ones = 0;
        bad = 0;
        for (int c = 0; c < 128; c++) begin
            if (en_out === 4'hF) ones++;
            if (en_out !== exp_en()) bad++;
            @(negedge Clk);
        end
        check("blink_dark_cycles", ones, 64);
        check("blink_scan", bad, 0);
        Blink_en = 1'b0;
        @(negedge Clk);

        // Randomized values against the decimal reference model.
        for (int t = 0; t < 20; t++) begin
            case ($urandom_range(0, 2))
                0:       num = int'($urandom_range(0, 65535));
                1:       num = int'($urandom_range(0, 99));
                default: num = int'($urandom_range(0, 12000));
            endcase
            Blank_lz = 1'($urandom_range(0, 1));
            start_load(num);
            run_convert(-1, 0, n, bad);
            check($sformatf("rand%0d_busy(%0d)", t, num), n, 16);
            check($sformatf("rand%0d_hold", t), bad, 0);
            check($sformatf("rand%0d_overflow", t), int'(Overflow), (num >= 10000) ? 1 : 0);
            prev_val = num;
            check_disp($sformatf("rand%0d_display(%0d)", t, num), num, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
